// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, NOP encoding, reset PC and
// base opcodes used by the fetch stage and the decoders.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage: sequential PC+4 or the control-flow
// target, plus a flag for a taken target that is not word aligned.
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  // Modular add: the top word wraps to address zero without any fault.
  assign pc_plus4 = pc + XLEN'(4);
  assign next_pc  = pc_src ? pc_target : pc_plus4;
  assign misalign = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the architectural PC, fetches over a req/ready
// handshake and hands one instruction at a time to the controller.
//
// Handshake: imem_req stays high with imem_addr stable until the cycle
// imem_ready is sampled high; imem_rdata is captured in that same cycle.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            PC_src,
  input  logic [XLEN-1:0] PC_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] instret,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] instret_q, instret_d;

  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            consume;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc        (pc_q),
    .pc_src    (PC_src),
    .pc_target (PC_target),
    .pc_plus4  (PC_plus4),
    .next_pc   (next_pc),
    .misalign  (misalign)
  );

  assign consume = (state_q == ST_VALID) && !stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ready) state_d = ST_VALID;
      ST_VALID: if (consume) state_d = misalign ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_VALID);
  end

  // Architectural registers only move on a memory capture or a consume.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    instret_d    = instret_q;
    if (state_q == ST_FETCH && imem_ready) begin
      instr_d = imem_rdata;
      pc_d    = fetch_pc_q;
    end
    if (consume) begin
      instret_d = instret_q + XLEN'(1);
      if (misalign) begin
        fault_d      = 1'b1;
        fault_addr_d = PC_target;
      end else begin
        fetch_pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      instret_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      instret_q    <= instret_d;
    end
  end

  assign imem_addr      = fetch_pc_q;
  assign instr          = instr_q;
  assign PC             = pc_q;
  assign opcode         = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7b5       = instr_q[30];
  assign misalign_fault = fault_q;
  assign fault_addr     = fault_addr_q;
  assign instret        = instret_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table from reset through
// stalls, wait states and a misaligned jump, then hand-written reset sequences.
module tb_fetch_unit;
  import rv32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        PC_src = 1'b0;
  logic [31:0] PC_target = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        misalign_fault;
  logic [31:0] fault_addr;
  logic [31:0] instret;
  fetch_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .PC_src         (PC_src),
    .PC_target      (PC_target),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .PC             (PC),
    .PC_plus4       (PC_plus4),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7b5       (funct7b5),
    .misalign_fault (misalign_fault),
    .fault_addr     (fault_addr),
    .instret        (instret),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_instret;
    logic        e_fault;
    logic [31:0] e_faddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic src, logic [31:0] tgt, logic rdy,
                              logic [31:0] rd, logic req, logic [31:0] addr,
                              logic vld, logic [31:0] pc, logic [31:0] ins,
                              logic [31:0] ir, logic flt, logic [31:0] fa);
    vec_t v;
    v.stall = st; v.pc_src = src; v.target = tgt; v.ready = rdy; v.rdata = rd;
    v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_pc = pc;
    v.e_instr = ins; v.e_instret = ir; v.e_fault = flt; v.e_faddr = fa;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs just after the falling edge, sample 1ns later
  task automatic drive(input logic st, input logic src, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rd);
    @(negedge clock);
    stall = st; PC_src = src; PC_target = tgt; imem_ready = rdy; imem_rdata = rd;
    #1;
  endtask

  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] I1 = 32'h40B5_0533;
  localparam logic [31:0] I2 = 32'h00A0_0113;
  localparam logic [31:0] I3 = 32'h0000_006F;
  localparam logic [31:0] I4 = 32'h0000_0063;

  initial begin
    // st src target rdy rdata | req addr valid pc instr instret fault faddr
    vecs.push_back(mk(0,0,0,1,I0,       0,32'h0,  0,32'h0,  NOP_INSTR,0,0,0)); // BOOT
    vecs.push_back(mk(0,0,0,1,I0,       1,32'h0,  0,32'h0,  NOP_INSTR,0,0,0)); // FETCH 0
    vecs.push_back(mk(0,0,0,1,I0,       0,32'h0,  1,32'h0,  I0,       0,0,0)); // VALID
    vecs.push_back(mk(0,0,0,1,I1,       1,32'h4,  0,32'h0,  I0,       1,0,0)); // FETCH 4
    vecs.push_back(mk(0,0,0,1,I1,       0,32'h0,  1,32'h4,  I1,       1,0,0));
    vecs.push_back(mk(0,0,0,0,32'hFFFF_FFFF,1,32'h8,0,32'h4,I1,       2,0,0)); // wait 1
    vecs.push_back(mk(0,0,0,0,32'hFFFF_FFFF,1,32'h8,0,32'h4,I1,       2,0,0)); // wait 2
    vecs.push_back(mk(0,0,0,0,32'hFFFF_FFFF,1,32'h8,0,32'h4,I1,       2,0,0)); // wait 3
    vecs.push_back(mk(0,0,0,1,I2,       1,32'h8,  0,32'h4,  I1,       2,0,0));
    vecs.push_back(mk(1,1,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0)); // stall x5
    vecs.push_back(mk(1,0,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0));
    vecs.push_back(mk(1,1,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0));
    vecs.push_back(mk(1,0,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0));
    vecs.push_back(mk(1,1,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0));
    vecs.push_back(mk(0,1,32'h100,1,I3, 0,32'h0,  1,32'h8,  I2,       2,0,0)); // take 0x100
    vecs.push_back(mk(0,0,0,1,I3,       1,32'h100,0,32'h8,  I2,       3,0,0));
    vecs.push_back(mk(0,1,32'h40,1,I4,  0,32'h0,  1,32'h100,I3,       3,0,0));
    vecs.push_back(mk(0,0,0,1,I4,       1,32'h40, 0,32'h100,I3,       4,0,0));
    vecs.push_back(mk(0,1,32'h22,1,I4,  0,32'h0,  1,32'h40, I4,       4,0,0)); // misaligned
    vecs.push_back(mk(0,0,0,1,I4,       0,32'h0,  0,32'h40, I4,       5,1,32'h22)); // HALT
    vecs.push_back(mk(0,1,32'h80,1,I4,  0,32'h0,  0,32'h40, I4,       5,1,32'h22));

    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string tag;
      v = vecs[i];
      tag = $sformatf("v%0d", i);
      drive(v.stall, v.pc_src, v.target, v.ready, v.rdata);
      chk({tag, ".req"},   32'(imem_req),    32'(v.e_req));
      if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v.e_valid));
      chk({tag, ".pc"},    PC,               v.e_pc);
      chk({tag, ".pc4"},   PC_plus4,         v.e_pc + 32'd4);
      chk({tag, ".instr"}, instr,            v.e_instr);
      chk({tag, ".op"},    32'(opcode),      32'(v.e_instr[6:0]));
      chk({tag, ".f3"},    32'(funct3),      32'(v.e_instr[14:12]));
      chk({tag, ".f7b5"},  32'(funct7b5),    32'(v.e_instr[30]));
      chk({tag, ".iret"},  instret,          v.e_instret);
      chk({tag, ".flt"},   32'(misalign_fault), 32'(v.e_fault));
      chk({tag, ".fa"},    fault_addr,       v.e_faddr);
    end

    // reset out of HALT clears the fault
    reset = 1'b1;
    #1;
    chk("halt_rst.flt",   32'(misalign_fault), 32'd0);
    chk("halt_rst.fa",    fault_addr,          32'd0);
    chk("halt_rst.iret",  instret,             32'd0);
    chk("halt_rst.instr", instr,               NOP_INSTR);
    chk("halt_rst.req",   32'(imem_req),       32'd0);
    @(posedge clock);
    #2 reset = 1'b0;

    // top-of-memory wrap: 0xFFFF_FFFC + 4 -> 0 with no fault
    drive(0, 0, 32'h0, 1, I0);
    chk("wrap.boot_req", 32'(imem_req), 32'd0);
    drive(0, 0, 32'h0, 1, I0);
    chk("wrap.f0_addr", imem_addr, 32'h0);
    drive(0, 1, 32'hFFFF_FFFC, 1, I0);
    chk("wrap.v0_valid", 32'(instr_valid), 32'd1);
    drive(0, 0, 32'h0, 1, I2);
    chk("wrap.f1_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("wrap.v1_pc",  PC,       32'hFFFF_FFFC);
    chk("wrap.v1_pc4", PC_plus4, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("wrap.f2_req",  32'(imem_req), 32'd1);
    chk("wrap.f2_addr", imem_addr,     32'h0);
    chk("wrap.flt",     32'(misalign_fault), 32'd0);
    chk("wrap.iret",    instret,       32'd2);

    // async reset while FETCH waits; a late ready must be dropped
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("mid.req_before", 32'(imem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid.req_async",   32'(imem_req),    32'd0);
    chk("mid.valid_async", 32'(instr_valid), 32'd0);
    chk("mid.pc_async",    PC,               32'h0);
    @(negedge clock);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clock);
    #2 reset = 1'b0;
    drive(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    chk("mid.boot_req",   32'(imem_req), 32'd0);
    chk("mid.boot_instr", instr,         NOP_INSTR);
    chk("mid.boot_iret",  instret,       32'd0);
    drive(0, 0, 32'h0, 1, I1);
    chk("mid.f_req",  32'(imem_req), 32'd1);
    chk("mid.f_addr", imem_addr,     32'h0);
    drive(0, 0, 32'h0, 1, I1);
    chk("mid.v_valid", 32'(instr_valid), 32'd1);
    chk("mid.v_instr", instr,            I1);
    chk("mid.v_pc",    PC,               32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
RV32I instruction fetch stage directly upstream of the controller and datapath. Holds the architectural PC and requests instructions from instruction memory over a req/ready handshake. Presents the fetched instruction plus its opcode/funct3/funct7b5 fields to the controller, and consumes the controller's PC_src and the datapath's branch/jump target to select the next PC. Also flags misaligned control-flow targets and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be word aligned)
XLEN, 32, address/data width (only 32 supported)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
PC_src  input  1  from controller: take PC_target for next PC (branch & zero | jump)
PC_target  input  32  branch/jump target from datapath
stall  input  1  downstream not ready; hold the current instruction
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of the request (byte address, bits [1:0]=0)
imem_ready  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  registered instruction
instr_valid  output  1  instr/PC valid for the controller/datapath
PC  output  32  address of instr
PC_plus4  output  32  PC + 4, for JAL/JALR link value
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7b5  output  1  instr[30]
misalign_fault  output  1  sticky: a taken target had bits [1:0] != 0
fault_addr  output  32  offending PC_target
instret  output  32  retired-instruction counter

Behaviour:
- Reset (async, any state, including mid-fetch): state=BOOT; fetch_pc=RESET_PC; PC=RESET_PC; instr=32'h0000_0013 (NOP); instr_valid=0; imem_req=0; misalign_fault=0; fault_addr=0; instret=0. An in-flight memory response is abandoned; memory must tolerate a dropped req.
- States: BOOT, FETCH, VALID, HALT.
- BOOT: outputs idle; next cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=fetch_pc, held stable until imem_ready. On imem_ready: instr<=imem_rdata, PC<=fetch_pc, -> VALID. stall and PC_src are ignored in FETCH.
- VALID: instr_valid=1, imem_req=0, imem_ready ignored. Consume occurs when stall=0:
  - instret<=instret+1 (wraps at 2^32).
  - next = PC_src ? PC_target : PC_plus4.
  - If PC_src=1 and PC_target[1:0]!=0: misalign_fault<=1, fault_addr<=PC_target, -> HALT.
  - Otherwise fetch_pc<=next, -> FETCH.
  - stall=1: hold instr/PC/fields unchanged; PC_src/PC_target are not sampled.
- HALT: instr_valid=0, imem_req=0; exit only by reset.
- Latency: zero-wait memory gives one instruction every 2 cycles (FETCH, VALID). Each imem wait state adds one cycle.
- Arithmetic: PC_plus4 is a 32-bit modular add; 0xFFFF_FFFC + 4 = 0x0000_0000 with no fault.
- opcode/funct3/funct7b5 are combinational slices of registered instr, so they are NOP fields until the first valid instruction.
- The controller is combinational on these fields, so PC_src is valid in the same VALID cycle.

Decomposition:
- Shared package rv32i_pkg holds:
  - fetch state enum (BOOT/FETCH/VALID/HALT)
  - NOP encoding 32'h0000_0013
  - default RESET_PC
  - opcode constants shared with the decoders
- One natural sub-module, pc_next (combinational), which computes:
  - PC_plus4
  - the next-PC mux
  - the misalignment flag
- The FSM and registers stay in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, imem_ready always 1, rdata=0x00500093 -> BOOT 1 cycle; imem_addr=0 in FETCH; next cycle instr_valid=1, PC=0, opcode=7'h13, funct3=0; next fetch at 0x4; instret=1.
- imem_ready held low 3 cycles at addr 0x8 -> imem_req=1 and imem_addr=0x8 stable all 3 cycles; instr_valid=0 throughout; VALID on the 4th cycle.
- VALID with stall=1 for 5 cycles, PC_src toggling, PC_target=0x100 -> instr/PC unchanged, no imem_req, instret unchanged. Then stall=0, PC_src=1 -> next imem_addr=0x100.
- PC=0x40, PC_src=1, PC_target=0x22 -> misalign_fault=1, fault_addr=0x22, HALT. No further imem_req until reset; reset clears the fault.
- PC=0xFFFF_FFFC, PC_src=0 consume -> PC_plus4=0; next imem_addr=0x0000_0000; no fault.
- Assert reset while FETCH is waiting (imem_ready=0) -> imem_req drops immediately (async); a late imem_ready is ignored; fetch restarts at RESET_PC after BOOT.
